// File: rtl/axis_packet_fifo.sv
// ============================================================================
// Module      : axis_packet_fifo
// Description : AXI-Stream store-and-forward packet FIFO. A frame only becomes
//               visible downstream once its tlast beat is stored. Frames that
//               cannot fit in the buffer are discarded. Optional error-frame
//               dropping (s_tuser_i on tlast) is enabled by defining
//               AXIS_PACKET_FIFO_ERROR_DROP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_packet_fifo #(
    parameter int WIDTH = 8,
    parameter int ABITS = 4
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             s_tvalid_i,
    output logic             s_tready_o,
    input  logic             s_tlast_i,
    input  logic             s_tuser_i,
    input  logic [WIDTH-1:0] s_tdata_i,
    output logic             m_tvalid_o,
    input  logic             m_tready_i,
    output logic             m_tlast_o,
    output logic [WIDTH-1:0] m_tdata_o,
    output logic             drop_o,
    output logic [ABITS:0]   level_o
);

    localparam int             c_asize      = 1 << ABITS;
    localparam logic [ABITS:0] c_full_level = {1'b1, {ABITS{1'b0}}};

    typedef enum logic [0:0] {
        ST_RECV    = 1'b0,
        ST_DISCARD = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [ABITS:0] r_wr_ptr;
    logic [ABITS:0] r_cm_ptr;
    logic [ABITS:0] r_rd_ptr;
    logic [ABITS:0] r_level;
    logic           r_drop;
    logic [ABITS:0] w_wr_nxt;
    logic [ABITS:0] w_cm_nxt;
    logic [ABITS:0] w_rd_nxt;
    logic [ABITS:0] w_wr_inc;
    logic           w_drop_nxt;
    logic           w_store;
    logic           w_full;
    logic           w_has_committed;
    logic           w_push;
    logic           w_pop;
    logic           w_frame_err;

    // Each entry holds {tlast, tdata}; contents are never reset.
    logic [WIDTH:0] r_mem [c_asize];

    assign w_full          = (r_wr_ptr - r_rd_ptr) == c_full_level;
    assign w_has_committed = (r_rd_ptr != r_cm_ptr);
    assign s_tready_o      = (r_state == ST_DISCARD) ? 1'b1 : ~w_full;
    assign m_tvalid_o      = w_has_committed;
    assign {m_tlast_o, m_tdata_o} = r_mem[r_rd_ptr[ABITS-1:0]];

    assign w_push   = s_tvalid_i & s_tready_o;
    assign w_pop    = m_tvalid_o & m_tready_i;
    assign w_wr_inc = r_wr_ptr + 1'b1;
    assign w_rd_nxt = w_pop ? (r_rd_ptr + 1'b1) : r_rd_ptr;
    assign w_store  = w_push & (r_state == ST_RECV);

`ifdef AXIS_PACKET_FIFO_ERROR_DROP_EN
    assign w_frame_err = s_tuser_i;
`else
    // Error flag has no effect in this build; the port is kept for compatibility.
    assign w_frame_err = s_tuser_i & 1'b0;
`endif

    assign drop_o  = r_drop;
    assign level_o = r_level;

    // Next-state decode for the write side: commit, rewind and discard decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_wr_nxt    = r_wr_ptr;
        w_cm_nxt    = r_cm_ptr;
        w_drop_nxt  = 1'b0;
        case (r_state)
            ST_RECV: begin
                if (w_full && !w_has_committed) begin
                    // Buffer is entirely one partial frame that can never
                    // complete; give it up rather than stall forever.
                    w_wr_nxt    = r_cm_ptr;
                    w_state_nxt = ST_DISCARD;
                end else if (w_push) begin
                    if (s_tlast_i) begin
                        if (w_frame_err) begin
                            w_wr_nxt   = r_cm_ptr;
                            w_drop_nxt = 1'b1;
                        end else begin
                            w_wr_nxt = w_wr_inc;
                            w_cm_nxt = w_wr_inc;
                        end
                    end else if (((w_wr_inc - r_rd_ptr) == c_full_level) && !w_has_committed) begin
                        // Frame alone fills the buffer: it is oversize.
                        w_wr_nxt    = r_cm_ptr;
                        w_state_nxt = ST_DISCARD;
                    end else begin
                        w_wr_nxt = w_wr_inc;
                    end
                end
            end
            ST_DISCARD: begin
                if (w_push && s_tlast_i) begin
                    w_state_nxt = ST_RECV;
                    w_drop_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = ST_RECV;
        endcase
    end

    // Register FSM state, pointers, drop pulse and fill level.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state  <= ST_RECV;
            r_wr_ptr <= '0;
            r_cm_ptr <= '0;
            r_rd_ptr <= '0;
            r_drop   <= 1'b0;
            r_level  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_ptr <= w_wr_nxt;
            r_cm_ptr <= w_cm_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_drop   <= w_drop_nxt;
            r_level  <= w_wr_nxt - w_rd_nxt;
        end
    end

    // Storage write port.
    always_ff @(posedge aclk) begin
        if (w_store) begin
            r_mem[r_wr_ptr[ABITS-1:0]] <= {s_tlast_i, s_tdata_i};
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axis_packet_fifo.sv
// ============================================================================
// Module      : tb_axis_packet_fifo
// Description : Directed and randomized self-checking bench for
//               axis_packet_fifo (WIDTH=8, ABITS=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_packet_fifo;

    localparam int c_width = 8;
    localparam int c_abits = 4;
    localparam int c_beats = 10000;
    localparam int c_budget = 80000;

    logic               aclk = 1'b0;
    logic               aresetn = 1'b0;
    logic               s_tvalid = 1'b0;
    logic               s_tready;
    logic               s_tlast = 1'b0;
    logic               s_tuser = 1'b0;
    logic [c_width-1:0] s_tdata = '0;
    logic               m_tvalid;
    logic               m_tready = 1'b0;
    logic               m_tlast;
    logic [c_width-1:0] m_tdata;
    logic               drop;
    logic [c_abits:0]   level;

    int total = 0;
    int bad = 0;

    axis_packet_fifo #(.WIDTH(c_width), .ABITS(c_abits)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .s_tvalid_i (s_tvalid),
        .s_tready_o (s_tready),
        .s_tlast_i  (s_tlast),
        .s_tuser_i  (s_tuser),
        .s_tdata_i  (s_tdata),
        .m_tvalid_o (m_tvalid),
        .m_tready_i (m_tready),
        .m_tlast_o  (m_tlast),
        .m_tdata_o  (m_tdata),
        .drop_o     (drop),
        .level_o    (level)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One accepted upstream beat; ready is checked before the edge.
    task automatic send(input logic [7:0] d, input logic last, input logic user);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = last;
        s_tuser  = user;
        chk("send_ready", {31'd0, s_tready}, 32'd1);
        tick();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    initial begin
        logic [8:0] exp_q[$];
        logic [8:0] sb[$];
        logic [8:0] beat;
        int sent;
        int recvd;
        int cyc;
        int rem;
        int drops;
        bit push;
        bit pop;

        // ---------------- reset ----------------
        aresetn = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
        chk("rst_mvalid", {31'd0, m_tvalid}, 32'd0);
        chk("rst_sready", {31'd0, s_tready}, 32'd1);
        chk("rst_level", {27'd0, level}, 32'd0);
        chk("rst_drop", {31'd0, drop}, 32'd0);

        // ---------------- frame hold ----------------
        m_tready = 1'b1;
        send(8'h11, 1'b0, 1'b0);
        chk("hold_mvalid1", {31'd0, m_tvalid}, 32'd0);
        chk("hold_level1", {27'd0, level}, 32'd1);
        send(8'h22, 1'b0, 1'b0);
        chk("hold_mvalid2", {31'd0, m_tvalid}, 32'd0);
        chk("hold_level2", {27'd0, level}, 32'd2);
        send(8'h33, 1'b1, 1'b0);
        chk("hold_mvalid3", {31'd0, m_tvalid}, 32'd1);
        chk("hold_level3", {27'd0, level}, 32'd3);
        chk("hold_d0", {23'd0, m_tlast, m_tdata}, 32'h011);
        tick();
        chk("hold_d1", {23'd0, m_tlast, m_tdata}, 32'h022);
        chk("hold_v1", {31'd0, m_tvalid}, 32'd1);
        tick();
        chk("hold_d2", {23'd0, m_tlast, m_tdata}, 32'h133);
        chk("hold_v2", {31'd0, m_tvalid}, 32'd1);
        tick();
        chk("hold_empty", {31'd0, m_tvalid}, 32'd0);
        chk("hold_level0", {27'd0, level}, 32'd0);

        // ---------------- backpressure ----------------
        m_tready = 1'b0;
        for (int i = 0; i < 16; i++) send(8'(i), (i % 8) == 7, 1'b0);
        chk("bp_sready_full", {31'd0, s_tready}, 32'd0);
        chk("bp_level16", {27'd0, level}, 32'd16);
        chk("bp_mvalid", {31'd0, m_tvalid}, 32'd1);
        // Offered beat while full with committed data stalls, no discard.
        s_tvalid = 1'b1;
        s_tdata  = 8'hEE;
        tick();
        tick();
        chk("bp_stall_level", {27'd0, level}, 32'd16);
        chk("bp_stall_drop", {31'd0, drop}, 32'd0);
        chk("bp_stall_ready", {31'd0, s_tready}, 32'd0);
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        tick();
        m_tready = 1'b0;
        chk("bp_ready_after_read", {31'd0, s_tready}, 32'd1);
        chk("bp_level15", {27'd0, level}, 32'd15);
        m_tready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            chk("bp_drain", {23'd0, m_tlast, m_tdata}, {23'd0, ((i % 8) == 7), 8'(i)});
            tick();
        end
        m_tready = 1'b0;
        chk("bp_empty", {31'd0, m_tvalid}, 32'd0);
        chk("bp_level0", {27'd0, level}, 32'd0);

        // ---------------- oversize ----------------
        for (int i = 0; i < 20; i++) begin
            send(8'h40 + 8'(i), i == 19, 1'b0);
            chk("ovs_drop", {31'd0, drop}, {31'd0, (i == 19)});
            chk("ovs_mvalid", {31'd0, m_tvalid}, 32'd0);
            if (i == 14) chk("ovs_level15", {27'd0, level}, 32'd15);
            if (i == 15) chk("ovs_level_rewind", {27'd0, level}, 32'd0);
        end
        chk("ovs_level_end", {27'd0, level}, 32'd0);
        tick();
        chk("ovs_drop_clear", {31'd0, drop}, 32'd0);
        chk("ovs_mvalid_end", {31'd0, m_tvalid}, 32'd0);

        // ---------------- error drop ----------------
        send(8'hA1, 1'b0, 1'b0);
        send(8'hA2, 1'b1, 1'b0);
        send(8'hB1, 1'b0, 1'b0);
        send(8'hB2, 1'b0, 1'b0);
        send(8'hB3, 1'b1, 1'b1);
`ifdef AXIS_PACKET_FIFO_ERROR_DROP_EN
        chk("err_drop", {31'd0, drop}, 32'd1);
`else
        chk("err_drop", {31'd0, drop}, 32'd0);
`endif
        send(8'hC1, 1'b1, 1'b0);
        chk("err_drop_clear", {31'd0, drop}, 32'd0);
        exp_q.push_back(9'h0A1);
        exp_q.push_back(9'h1A2);
`ifdef AXIS_PACKET_FIFO_ERROR_DROP_EN
        chk("err_level", {27'd0, level}, 32'd3);
`else
        chk("err_level", {27'd0, level}, 32'd6);
        exp_q.push_back(9'h0B1);
        exp_q.push_back(9'h0B2);
        exp_q.push_back(9'h1B3);
`endif
        exp_q.push_back(9'h1C1);
        m_tready = 1'b1;
        while (exp_q.size() > 0) begin
            chk("err_mvalid", {31'd0, m_tvalid}, 32'd1);
            chk("err_data", {23'd0, m_tlast, m_tdata}, {23'd0, exp_q.pop_front()});
            tick();
        end
        chk("err_empty", {31'd0, m_tvalid}, 32'd0);

        // ---------------- mid-frame reset ----------------
        for (int i = 0; i < 5; i++) send(8'h60 + 8'(i), 1'b0, 1'b0);
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        chk("mrst_mvalid", {31'd0, m_tvalid}, 32'd0);
        chk("mrst_level", {27'd0, level}, 32'd0);
        m_tready = 1'b0;
        send(8'hAA, 1'b1, 1'b0);
        chk("mrst_mvalid_aa", {31'd0, m_tvalid}, 32'd1);
        chk("mrst_data_aa", {23'd0, m_tlast, m_tdata}, 32'h1AA);
        m_tready = 1'b1;
        tick();
        chk("mrst_empty", {31'd0, m_tvalid}, 32'd0);
        chk("mrst_level0", {27'd0, level}, 32'd0);

        // ---------------- concurrent random traffic ----------------
        sent = 0;
        recvd = 0;
        cyc = 0;
        rem = 0;
        drops = 0;
        s_tvalid = 1'b0;
        while (recvd < c_beats && cyc < c_budget && bad < 20) begin
            if (!s_tvalid && sent < c_beats && $urandom_range(0, 1) == 1) begin
                if (rem == 0) begin
                    rem = $urandom_range(1, 12);
                    if (rem > c_beats - sent) rem = c_beats - sent;
                end
                s_tdata  = 8'($urandom);
                s_tlast  = (rem == 1);
                s_tvalid = 1'b1;
            end
            m_tready = ($urandom_range(0, 1) == 1);
            push = s_tvalid && s_tready;
            pop  = m_tvalid && m_tready;
            if (pop) begin
                if (sb.size() == 0) begin
                    chk("rnd_underflow", 32'd1, 32'd0);
                end else begin
                    beat = sb.pop_front();
                    chk("rnd_data", {23'd0, m_tlast, m_tdata}, {23'd0, beat});
                end
                recvd++;
            end
            if (push) begin
                sb.push_back({s_tlast, s_tdata});
                sent++;
                rem--;
            end
            tick();
            if (drop) drops++;
            if (push) s_tvalid = 1'b0;
            cyc++;
        end
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        chk("rnd_in_time", {31'd0, (cyc < c_budget)}, 32'd1);
        chk("rnd_recvd", recvd, c_beats);
        chk("rnd_sb_empty", sb.size(), 32'd0);
        chk("rnd_no_drop", drops, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axis_packet_fifo.md
AXIS_PACKET_FIFO -- requirements
Module: axis_packet_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning tdata width in bits.
REQ-002 The block SHALL have parameter ABITS, default 4, meaning address bits; capacity ASIZE = 2^ABITS beats.
REQ-003 The block SHALL have the following ports, in this order:
  - aclk  input  1  sole clock; all logic on rising edge.
  - aresetn  input  1  reset; synchronous, active-low.
  - s_tvalid_i  input  1  upstream beat valid.
  - s_tready_o  output  1  upstream ready.
  - s_tlast_i  input  1  last beat of frame.
  - s_tuser_i  input  1  frame-error flag, sampled on the tlast beat.
  - s_tdata_i  input  WIDTH  upstream data.
  - m_tvalid_o  output  1  downstream valid.
  - m_tready_i  input  1  downstream ready.
  - m_tlast_o  output  1  last beat of frame.
  - m_tdata_o  output  WIDTH  downstream data.
  - drop_o  output  1  one-cycle pulse when a frame is discarded.
  - level_o  output  ABITS+1  stored beats, committed plus uncommitted.

Function
REQ-010 The block SHALL operate store-and-forward: a frame SHALL NOT be visible downstream until its tlast beat has been written.
REQ-011 Pointers:
  - wr_ptr, cm_ptr (commit) and rd_ptr SHALL each be ABITS+1 bits and wrap modulo 2^(ABITS+1).
  - Storage is indexed by the low ABITS bits.
REQ-012 An upstream transfer SHALL occur when s_tvalid_i & s_tready_o; a downstream transfer SHALL occur when m_tvalid_o & m_tready_i.
REQ-013 Each stored entry SHALL be {tlast, tdata}.
REQ-014 m_tvalid_o SHALL be (rd_ptr != cm_ptr), and m_tdata_o/m_tlast_o SHALL equal the entry at rd_ptr with zero-cycle read latency.
REQ-015 Full SHALL be (wr_ptr - rd_ptr == ASIZE), and s_tready_o SHALL be ~full in state RECV and 1 in state DISCARD.
REQ-016 The write FSM SHALL have states RECV and DISCARD, with reset state RECV.
REQ-017 In RECV, an accepted non-last beat SHALL be written and increment wr_ptr.
REQ-018 In RECV, an accepted tlast beat SHALL be written, and cm_ptr SHALL become wr_ptr+1 on the same edge, so the frame is visible on the next cycle.
REQ-019 Oversize frame: if an accepted non-last beat makes wr_ptr - rd_ptr == ASIZE while rd_ptr == cm_ptr, the FSM SHALL enter DISCARD.
  - On that edge, wr_ptr SHALL rewind to cm_ptr.
REQ-020 In DISCARD, beats SHALL be accepted and not stored; the tlast beat SHALL return the FSM to RECV and pulse drop_o for one cycle.
REQ-021 With committed data present (rd_ptr != cm_ptr) and full, s_tready_o SHALL deassert, and input SHALL stall until reads free space; no discard SHALL occur in this case.
REQ-022 Simultaneous read and write SHALL both take effect on the same edge.
  - level_o SHALL equal wr_ptr - rd_ptr, registered, and unchanged when one beat is written and one read on the same edge.
REQ-023 A read SHALL never pass cm_ptr, and uncommitted beats SHALL never appear on the m_ interface.

Reset
REQ-030 While aresetn is low at a rising edge, wr_ptr, cm_ptr and rd_ptr SHALL be set to 0, the FSM to RECV, and drop_o to 0.
REQ-031 After reset, m_tvalid_o=0, s_tready_o=1 and level_o=0 SHALL hold; storage contents are not reset.
REQ-032 Reset asserted mid-frame SHALL discard all stored and partial frames.
  - The first beat after reset SHALL be treated as the start of a new frame.

Configuration
REQ-040 The error-drop feature SHALL be compiled in by macro AXIS_PACKET_FIFO_ERROR_DROP_EN.
REQ-041 With AXIS_PACKET_FIFO_ERROR_DROP_EN defined, an accepted tlast beat in RECV with s_tuser_i=1 SHALL NOT commit.
  - wr_ptr SHALL rewind to cm_ptr and drop_o SHALL pulse for one cycle.
REQ-042 Without the macro, s_tuser_i SHALL be ignored and every complete frame SHALL be committed; the port SHALL remain present.

Verification
REQ-050 Frame hold: ABITS=4; write 3 beats 0x11,0x22,0x33 (tlast on 0x33), m_tready=1 -> m_tvalid_o=0 until the cycle after the 0x33 write, then 0x11,0x22,0x33 on consecutive cycles, m_tlast_o with 0x33, level_o back to 0.
REQ-051 Backpressure: m_tready=0; write two 8-beat frames -> s_tready_o=0 after 16 beats, level_o=16; one read -> s_tready_o=1 next cycle.
REQ-052 Oversize: empty FIFO, m_tready=0; send a 20-beat frame -> beat 16 triggers DISCARD, beats 17-20 accepted, drop_o pulses once after beat 20, m_tvalid_o stays 0, level_o=0.
REQ-053 Error drop, with macro: frame A (2 beats) is good, frame B (3 beats) has s_tuser_i=1 on tlast, frame C (1 beat) is good -> output is A then C only, one drop_o pulse.
  - Without the macro, the same stimulus -> A, B, C are all output and drop_o stays 0.
REQ-054 Mid-frame reset: write 5 beats with no tlast, then aresetn=0 for 1 cycle -> m_tvalid_o=0, level_o=0; then a 1-beat frame 0xAA -> only 0xAA is output.
REQ-055 Concurrent traffic: random valid/ready at 50% for 10,000 beats of random-length frames (1-12) -> the output stream equals the input frames in order, with no loss or duplication.
